// File: rtl/channel_splitter.sv
// Registered 1-to-4 demultiplexer for a single-bit stream: the selected channel
// carries the input bit, the other three are held low, all driven straight from flops.
module channel_splitter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       input_data,
    input  logic [1:0] channel_select,
    output logic       ch0,
    output logic       ch1,
    output logic       ch2,
    output logic       ch3
);

    logic [3:0] r_ch;
    logic [3:0] w_next;

    // Only the addressed bit can ever be set, so outputs are one-hot or all-zero.
    always_comb begin
        w_next                 = '0;
        w_next[channel_select] = input_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch <= '0;
        end else begin
            r_ch <= w_next;
        end
    end

    assign ch0 = r_ch[0];
    assign ch1 = r_ch[1];
    assign ch2 = r_ch[2];
    assign ch3 = r_ch[3];

endmodule

// File: tb/tb_channel_splitter.sv
// Self-checking bench for channel_splitter: directed scenarios plus random traffic
// compared against a behavioural routing model.
module tb_channel_splitter;

    logic       clk;
    logic       rst_n;
    logic       input_data;
    logic [1:0] channel_select;
    logic       ch0, ch1, ch2, ch3;
    logic [3:0] w_out;
    logic [3:0] r_exp;
    int         n_checks;
    int         n_errors;

    channel_splitter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .input_data     (input_data),
        .channel_select (channel_select),
        .ch0            (ch0),
        .ch1            (ch1),
        .ch2            (ch2),
        .ch3            (ch3)
    );

    assign w_out = {ch3, ch2, ch1, ch0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the channel numbered sel receives the data bit, all others are zero.
    function automatic logic [3:0] ref_route(input logic rst, input logic d, input logic [1:0] sel);
        logic [3:0] v;
        v = 4'b0000;
        if (rst && d) v = 4'(1 << int'(sel));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, then check just after the following rising edge.
    task automatic step(input string tag, input logic rst, input logic d, input logic [1:0] sel);
        @(negedge clk);
        rst_n          = rst;
        input_data     = d;
        channel_select = sel;
        @(posedge clk);
        r_exp = ref_route(rst, d, sel);
        #1;
        chk(tag, w_out, r_exp);
        chk({tag, "_onehot"}, {3'b000, ($countones(w_out) <= 1)}, 4'b0001);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        input_data     = 1'b1;
        channel_select = 2'd2;
        r_exp          = 4'b0000;

        step("reset0", 1'b0, 1'b1, 2'd2);
        step("reset1", 1'b0, 1'b1, 2'd2);

        step("sel0_d0", 1'b1, 1'b0, 2'd0);
        step("sel0_d1", 1'b1, 1'b1, 2'd0);

        step("sweep1", 1'b1, 1'b1, 2'd1);
        step("sweep2", 1'b1, 1'b1, 2'd2);
        step("sweep3", 1'b1, 1'b1, 2'd3);

        step("tog_a", 1'b1, 1'b0, 2'd3);
        step("tog_b", 1'b1, 1'b0, 2'd3);
        step("tog_c", 1'b1, 1'b1, 2'd3);

        // Mid-stream reset: outputs must hold until the rising edge.
        step("mid_pre", 1'b1, 1'b1, 2'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_hold", w_out, r_exp);
        @(posedge clk);
        r_exp = ref_route(1'b0, input_data, channel_select);
        #1;
        chk("mid_rst", w_out, r_exp);
        step("mid_release", 1'b1, 1'b1, 2'd1);

        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(0, 19) != 0), 1'($urandom), 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
